// File: rtl/sysid_info_regs.sv
// Avalon-MM system ID / build info slave: ID, timestamp, scratch, caps.
// Define SYSID_UPTIME_EN to build in the uptime counter, snapshot and CTRL.
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_4440,
  parameter logic [31:0] TIMESTAMP    = 32'd1386398321,
  parameter int          CNT_W        = 48,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_TS      = 3'd1;
  localparam logic [2:0] A_UP_LO   = 3'd2;
  localparam logic [2:0] A_UP_HI   = 3'd3;
  localparam logic [2:0] A_SCRATCH = 3'd4;
  localparam logic [2:0] A_CTRL    = 3'd5;
  localparam logic [2:0] A_CAPS    = 3'd6;
  localparam logic [2:0] A_RSVD    = 3'd7;

`ifdef SYSID_UPTIME_EN
  localparam logic CAP_UP = 1'b1;
`else
  localparam logic CAP_UP = 1'b0;
`endif

  localparam logic [31:0] CAPS = {
    19'd0, CAP_UP, 4'(READ_LATENCY), 8'(CNT_W)
  };

  logic [31:0] scratch;
  logic [31:0] be_mask;
  logic        wr_scratch;
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [31:0] ctrl_val;
  logic [31:0] rd_val;

  assign wr_scratch = write && (address == A_SCRATCH);

  always_comb begin
    be_mask = {
      {8{byteenable[3]}}, {8{byteenable[2]}},
      {8{byteenable[1]}}, {8{byteenable[0]}}
    };
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      scratch <= (scratch & ~be_mask) | (writedata & be_mask);
    end
  end

`ifdef SYSID_UPTIME_EN
  localparam int SH_W = CNT_W - 32;

  logic [CNT_W-1:0] counter;
  logic [SH_W-1:0]  shadow;
  logic             en;
  logic             wr_ctrl;
  logic             clr;
  logic             snap;

  assign wr_ctrl = write && (address == A_CTRL) && byteenable[0];
  assign clr     = wr_ctrl && writedata[1];
  assign snap    = read && (address == A_UP_LO);

  // CLR wins over the increment; EN takes the new value on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
      en      <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        en <= writedata[0];
      end
      if (clr) begin
        counter <= '0;
      end else if (en) begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

  // UP_HI returns the upper half captured by the last UP_LO read
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow <= '0;
    end else if (snap) begin
      shadow <= counter[CNT_W-1:32];
    end
  end

  always_comb begin
    up_hi             = '0;
    up_hi[SH_W-1:0]   = shadow;
  end

  assign up_lo    = counter[31:0];
  assign ctrl_val = {31'd0, en};
`else
  assign up_lo    = '0;
  assign up_hi    = '0;
  assign ctrl_val = '0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (address)
      A_ID:      rd_val = SYSTEM_ID;
      A_TS:      rd_val = TIMESTAMP;
      A_UP_LO:   rd_val = up_lo;
      A_UP_HI:   rd_val = up_hi;
      A_SCRATCH: rd_val = scratch;
      A_CTRL:    rd_val = ctrl_val;
      A_CAPS:    rd_val = CAPS;
      A_RSVD:    rd_val = '0;
      default:   rd_val = '0;
    endcase
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [31:0] p_data;
      logic        p_valid;

      always_ff @(posedge clock) begin
        if (reset) begin
          p_data  <= '0;
          p_valid <= 1'b0;
        end else begin
          p_valid <= read;
          if (read) begin
            p_data <= rd_val;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          readdata      <= '0;
          readdatavalid <= 1'b0;
        end else begin
          readdatavalid <= p_valid;
          if (p_valid) begin
            readdata <= p_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clock) begin
        if (reset) begin
          readdata      <= '0;
          readdatavalid <= 1'b0;
        end else begin
          readdatavalid <= read;
          if (read) begin
            readdata <= rd_val;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs at the default parameters (latency 1).
// Uptime expectations are selected with SYSID_UPTIME_EN.
module tb_sysid_info_regs;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int checks;
  int failures;

  localparam logic [31:0] ID_EXP = 32'h0000_4440;
  localparam logic [31:0] TS_EXP = 32'd1386398321;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS_EXP = 32'h0000_1130;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0000_0130;
`endif

  sysid_info_regs dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    read       = 1'b0;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rdchk(input logic [2:0] a, input logic [31:0] exp,
                       input string n);
    logic [31:0] d;
    logic        v;
    address = a;
    read    = 1'b1;
    write   = 1'b0;
    @(negedge clock);
    read = 1'b0;
    d    = readdata;
    v    = readdatavalid;
    chk({n, "_vld"}, 32'(v), 32'd1);
    chk(n, d, exp);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;

    do_reset();
    chk("rst_vld", 32'(readdatavalid), 32'd0);
    chk("rst_data", readdata, 32'd0);

    // back-to-back reads: one valid per cycle, in order
    address = 3'd0;
    read    = 1'b1;
    @(negedge clock);
    chk("b2b0_vld", 32'(readdatavalid), 32'd1);
    chk("b2b0", readdata, ID_EXP);
    address = 3'd1;
    @(negedge clock);
    chk("b2b1_vld", 32'(readdatavalid), 32'd1);
    chk("b2b1", readdata, TS_EXP);
    address = 3'd6;
    @(negedge clock);
    chk("b2b2_vld", 32'(readdatavalid), 32'd1);
    chk("b2b2", readdata, CAPS_EXP);
    read = 1'b0;
    @(negedge clock);
    chk("b2b_idle_vld", 32'(readdatavalid), 32'd0);

    vt.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h0, "scr_rst"});
    vt.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'h0, "rsvd"});
    vt.push_back('{1'b1, 3'd4, 32'hDEAD_BEEF, 4'b0101, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h00AD_00EF, "scr_be5"});
    vt.push_back('{1'b1, 3'd4, 32'h1122_3344, 4'b1010, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h11AD_33EF, "scr_beA"});
    vt.push_back('{1'b1, 3'd4, 32'hFFFF_FFFF, 4'b0000, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd4, 32'h0, 4'h0, 32'h11AD_33EF, "scr_be0"});
    vt.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd0, 32'h0, 4'h0, ID_EXP, "id_ro"});
    vt.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd1, 32'h0, 4'h0, TS_EXP, "ts_ro"});
    vt.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd6, 32'h0, 4'h0, CAPS_EXP, "caps_ro"});
    vt.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0, "w"});
    vt.push_back('{1'b0, 3'd7, 32'h0, 4'h0, 32'h0, "rsvd_ro"});

    foreach (vt[i]) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d, vt[i].be);
      else rdchk(vt[i].a, vt[i].exp, vt[i].name);
    end

    // read and write of the same word in one cycle returns the old value
    address    = 3'd4;
    writedata  = 32'h5555_AAAA;
    byteenable = 4'hF;
    read       = 1'b1;
    write      = 1'b1;
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    chk("rw_old_vld", 32'(readdatavalid), 32'd1);
    chk("rw_old", readdata, 32'h11AD_33EF);
    rdchk(3'd4, 32'h5555_AAAA, "rw_new");

    do_reset();
    rdchk(3'd4, 32'h0, "scr_after_rst");

    // reset sampled with a read in flight drops it
    address = 3'd0;
    read    = 1'b1;
    reset   = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk("rst_inflight_vld", 32'(readdatavalid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_inflight_vld2", 32'(readdatavalid), 32'd0);
    @(negedge clock);
    chk("rst_inflight_vld3", 32'(readdatavalid), 32'd0);

`ifdef SYSID_UPTIME_EN
    do_reset();
    rdchk(3'd5, 32'h1, "ctrl_rst");
    rdchk(3'd3, 32'h0, "hi_rst");
    do_reset();
    repeat (10) @(negedge clock);
    rdchk(3'd2, 32'd10, "up_cyc10");
    wr(3'd5, 32'h0, 4'hF);
    rdchk(3'd2, 32'd12, "en0_a");
    repeat (5) @(negedge clock);
    rdchk(3'd2, 32'd12, "en0_b");
    rdchk(3'd5, 32'h0, "ctrl_en0");
    wr(3'd5, 32'h1, 4'hF);
    rdchk(3'd5, 32'h1, "ctrl_en1");
    wr(3'd5, 32'h3, 4'hF);
    rdchk(3'd2, 32'd0, "clr_0");
    repeat (4) @(negedge clock);
    rdchk(3'd2, 32'd5, "clr_5");
    wr(3'd5, 32'h2, 4'hF);
    rdchk(3'd2, 32'd0, "clr_hold_a");
    repeat (3) @(negedge clock);
    rdchk(3'd2, 32'd0, "clr_hold_b");
    rdchk(3'd5, 32'h0, "ctrl_clr_rd0");
    wr(3'd5, 32'h1, 4'hF);
    force dut.counter = 48'h0000_FFFF_FFFF;
    #1;
    release dut.counter;
    rdchk(3'd2, 32'hFFFF_FFFF, "wrap_lo");
    rdchk(3'd3, 32'h0, "wrap_hi");
    rdchk(3'd2, 32'h1, "post_lo");
    rdchk(3'd3, 32'h1, "post_hi");
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    rdchk(3'd3, 32'h1, "hi_ro");
`else
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    rdchk(3'd2, 32'h0, "noup_lo");
    rdchk(3'd3, 32'h0, "noup_hi");
    rdchk(3'd5, 32'h0, "noup_ctrl");
    repeat (3) @(negedge clock);
    rdchk(3'd2, 32'h0, "noup_lo2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
# sysid_info_regs

Parametrised system-identification and build-information slave for the SOPC: an Avalon-MM target that returns a compile-time system ID and build timestamp and adds a free-running uptime counter with atomic 64-bit snapshot reads, a scratch register, a control register and a capabilities word. It replaces the fixed two-word ID slave on the control bus. Reads are pipelined with a configurable fixed latency and a `readdatavalid` strobe.

## Interface
- `SYSTEM_ID`, 32'h0000_4440, value returned at word 0
- `TIMESTAMP`, 32'd1386398321, build time (Unix seconds) returned at word 1
- `CNT_W`, 48, uptime counter width; legal 33..64
- `READ_LATENCY`, 1, read pipeline depth; legal 1 or 2

- `clock` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-high
- `address` in 3: word address
- `read` in 1: read request, accepted every cycle it is high (no waitrequest)
- `write` in 1: write request, accepted every cycle it is high
- `writedata` in 32: write data
- `byteenable` in 4: byte lanes for writes; ignored on reads
- `readdata` out 32: read data, valid only with `readdatavalid`
- `readdatavalid` out 1: one-cycle strobe per accepted read

## Operation
- Register map (word address):
  - 0 ID: `SYSTEM_ID`, RO
  - 1 TS: `TIMESTAMP`, RO
  - 2 UP_LO: counter[31:0]; same read loads shadow <= counter[CNT_W-1:32]
  - 3 UP_HI: shadow, zero-extended to 32 bits, RO
  - 4 SCRATCH: RW, per-byte via `byteenable`, reset 0
  - 5 CTRL: bit0 EN (RW, reset 1); bit1 CLR (write-1 pulse, reads 0); other bits read 0
  - 6 CAPS: [7:0]=CNT_W, [11:8]=READ_LATENCY, [12]=1 if uptime compiled in, rest 0
  - 7: reads 0, writes ignored
- Writes to RO/reserved addresses: no effect, no error.
- Counter: increments by 1 each cycle while EN=1; wraps from 2^CNT_W-1 to 0; holds while EN=0.
- CLR write: counter = 0 on next cycle; CLR beats increment; EN bit updated from same write.
- Read value sampled in acceptance cycle; `read`+`write` same cycle to same address returns pre-write value.
- Reset values: `readdata` 0, `readdatavalid` 0, counter 0, shadow 0, SCRATCH 0, EN 1.

## Timing
- Read accepted at cycle N -> `readdata`/`readdatavalid` at N+READ_LATENCY; valid high exactly one cycle per read.
- Back-to-back reads every cycle: one valid per cycle, in order, no bubbles.
- `readdata` holds last value when valid low (not required to be zero).
- Write effective at cycle N+1; read accepted at N+1 sees it.
- UP_LO at N captures counter value at N; UP_HI read any later cycle returns upper bits of that same snapshot until next UP_LO read.
- `reset` asserted mid-read: in-flight reads are dropped, `readdatavalid` 0 from the cycle after reset sampled high; all state returns to reset values.

## Configuration
- `SYSID_UPTIME_EN` defined: counter, shadow, CTRL as above; CAPS[12]=1.
- Not defined: counter and shadow logic absent; words 2, 3, 5 read 0 and ignore writes; CAPS[12]=0; all other words unchanged.

## Test plan
- After reset, read words 0,1,6 back-to-back (latency 1) -> 32'h0000_4440, 32'd1386398321, 32'h0000_1130 on three consecutive valid cycles.
- Write SCRATCH 32'hDEAD_BEEF with byteenable 4'b0101, then read -> 32'h00AD_00EF; reset, read -> 0.
- Reset, read UP_LO at cycle 10 -> 10 (latency-adjusted); CTRL write EN=0, two reads of UP_LO 5 cycles apart return equal values.
- Force counter near 2^32 (CLR then run 2^32-3 cycles, or a testbench `force`): read UP_LO then UP_HI while lower word wraps -> {HI,LO} equals snapshot, HI not incremented relative to LO.
- CLR write and increment same cycle -> next UP_LO read reports cycle count since CLR, starting from 0; reset asserted with a read in flight -> no `readdatavalid` after reset.
- Build without `SYSID_UPTIME_EN`: words 2,3,5 read 0 after writes of 32'hFFFF_FFFF; CAPS[12]=0.
